// File: rtl/sram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_arbiter_if                                                            |
// | One requester's command/response channel into the SRAM arbiter.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface sram_arbiter_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [1:0]            cmd_mask;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_mask,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_mask,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_arbiter                                                               |
// | Two-port arbiter and setup/access/hold sequencer for an async 16-bit SRAM. |
// | Option macro: SRAM_ARB_ROUND_ROBIN_EN (round-robin, else A-priority).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sram_arbiter #(
    parameter int ADDR_WIDTH  = 18,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  io_mainClk,
    input  logic                  io_asyncResetn,
    sram_arbiter_if.slave         io_a,
    sram_arbiter_if.slave         io_b,
    output logic [ADDR_WIDTH-1:0] io_sram_addr,
    input  logic [DATA_WIDTH-1:0] io_sram_dat_read,
    output logic [DATA_WIDTH-1:0] io_sram_dat_write,
    output logic                  io_sram_dat_writeEnable,
    output logic                  io_sram_cs,
    output logic                  io_sram_we,
    output logic                  io_sram_oe,
    output logic                  io_sram_ub,
    output logic                  io_sram_lb
);

    localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic                  port_q, port_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] dwr_q, dwr_d;
    logic                  wen_q, wen_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic                  ub_q, ub_d;
    logic                  lb_q, lb_d;
    logic                  rsp_a_q, rsp_a_d;
    logic                  rsp_b_q, rsp_b_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  grant_a, grant_b, idle, hs;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [1:0]            sel_mask;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // last_q = 1 means port B was granted most recently, so A wins the next tie.
    logic last_q;

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            last_q <= 1'b1;
        end else if (hs) begin
            last_q <= grant_b;
        end
    end

    always_comb begin
        grant_b = io_b.cmd_valid & (~io_a.cmd_valid | ~last_q);
    end
`else
    always_comb begin
        grant_b = io_b.cmd_valid & ~io_a.cmd_valid;
    end
`endif

    always_comb begin
        grant_a   = io_a.cmd_valid & ~grant_b;
        idle      = (state_q == S_IDLE) & io_asyncResetn;
        hs        = idle & (grant_a | grant_b);
        sel_write = grant_b ? io_b.cmd_write : io_a.cmd_write;
        sel_addr  = grant_b ? io_b.cmd_addr  : io_a.cmd_addr;
        sel_wdata = grant_b ? io_b.cmd_wdata : io_a.cmd_wdata;
        sel_mask  = grant_b ? io_b.cmd_mask  : io_a.cmd_mask;
    end

    assign io_a.cmd_ready = idle & grant_a;
    assign io_b.cmd_ready = idle & grant_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        port_d  = port_q;
        addr_d  = addr_q;
        dwr_d   = dwr_q;
        wen_d   = wen_q;
        cs_d    = cs_q;
        we_d    = we_q;
        oe_d    = oe_q;
        ub_d    = ub_q;
        lb_d    = lb_q;
        rsp_a_d = 1'b0;
        rsp_b_d = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    state_d = S_SETUP;
                    wr_d    = sel_write;
                    port_d  = grant_b;
                    addr_d  = sel_addr;
                    cs_d    = 1'b0;
                    cnt_d   = c_wait_load;
                    if (sel_write) begin
                        wen_d = 1'b1;
                        dwr_d = sel_wdata;
                        ub_d  = ~sel_mask[1];
                        lb_d  = ~sel_mask[0];
                    end else begin
                        ub_d  = 1'b0;
                        lb_d  = 1'b0;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                if (wr_q) begin
                    we_d = 1'b0;
                end else begin
                    oe_d = 1'b0;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                    we_d    = 1'b1;
                    oe_d    = 1'b1;
                    rsp_a_d = ~port_q;
                    rsp_b_d = port_q;
                    if (!wr_q) begin
                        rdata_d = io_sram_dat_read;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                // Write data stays on the bus through HOLD; release everything together.
                state_d = S_IDLE;
                cs_d    = 1'b1;
                ub_d    = 1'b1;
                lb_d    = 1'b1;
                wen_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            port_q  <= 1'b0;
            addr_q  <= '0;
            dwr_q   <= '0;
            wen_q   <= 1'b0;
            cs_q    <= 1'b1;
            we_q    <= 1'b1;
            oe_q    <= 1'b1;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
            rsp_a_q <= 1'b0;
            rsp_b_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            dwr_q   <= dwr_d;
            wen_q   <= wen_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            ub_q    <= ub_d;
            lb_q    <= lb_d;
            rsp_a_q <= rsp_a_d;
            rsp_b_q <= rsp_b_d;
            rdata_q <= rdata_d;
        end
    end

    assign io_sram_addr            = addr_q;
    assign io_sram_dat_write       = dwr_q;
    assign io_sram_dat_writeEnable = wen_q;
    assign io_sram_cs              = cs_q;
    assign io_sram_we              = we_q;
    assign io_sram_oe              = oe_q;
    assign io_sram_ub              = ub_q;
    assign io_sram_lb              = lb_q;

    assign io_a.rsp_valid = rsp_a_q;
    assign io_a.rsp_rdata = rdata_q;
    assign io_b.rsp_valid = rsp_b_q;
    assign io_b.rsp_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sram_arbiter                                                            |
// | Bench for sram_arbiter: SRAM pin model plus transaction-level reference.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sram_arbiter;
    localparam int W  = 2;
    localparam int AW = 18;
    localparam int DW = 16;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
    sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

    logic          cv[2];
    logic          cw[2];
    logic [AW-1:0] ca[2];
    logic [DW-1:0] cd[2];
    logic [1:0]    cm[2];
    assign ifa.cmd_valid = cv[0];
    assign ifa.cmd_write = cw[0];
    assign ifa.cmd_addr  = ca[0];
    assign ifa.cmd_wdata = cd[0];
    assign ifa.cmd_mask  = cm[0];
    assign ifb.cmd_valid = cv[1];
    assign ifb.cmd_write = cw[1];
    assign ifb.cmd_addr  = ca[1];
    assign ifb.cmd_wdata = cd[1];
    assign ifb.cmd_mask  = cm[1];

    logic [1:0] rdy, rv;
    assign rdy = {ifb.cmd_ready, ifa.cmd_ready};
    assign rv  = {ifb.rsp_valid, ifa.rsp_valid};

    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_dw, s_dr;
    logic          s_wen, s_cs, s_we, s_oe, s_ub, s_lb;

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W)) dut (
        .io_mainClk(clk), .io_asyncResetn(rst_n), .io_a(ifa), .io_b(ifb),
        .io_sram_addr(s_addr), .io_sram_dat_read(s_dr), .io_sram_dat_write(s_dw),
        .io_sram_dat_writeEnable(s_wen), .io_sram_cs(s_cs), .io_sram_we(s_we),
        .io_sram_oe(s_oe), .io_sram_ub(s_ub), .io_sram_lb(s_lb)
    );

    // Byte-lane asynchronous SRAM model; reads float to a marker value outside cs&oe.
    logic [15:0] sram [512];
    always @(posedge clk) begin
        if (!s_cs && !s_we) begin
            if (!s_lb) sram[s_addr[8:0]][7:0]  <= s_dw[7:0];
            if (!s_ub) sram[s_addr[8:0]][15:8] <= s_dw[15:8];
        end
    end
    assign s_dr = (!s_cs && !s_oe) ? sram[s_addr[8:0]] : 16'hDEAD;

    // Extra instances for the latency extremes, port A only.
    sram_arbiter_if x1a (), x1b (), x15a (), x15b ();
    logic          lv[2];
    logic [1:0]    lr, lrv;
    logic [AW-1:0] l_addr[2];
    logic [DW-1:0] l_dw[2];
    logic          l_wen[2], l_cs[2], l_we[2], l_oe[2], l_ub[2], l_lb[2];
    assign x1a.cmd_valid  = lv[0];
    assign x1a.cmd_write  = 1'b0;
    assign x1a.cmd_addr   = '0;
    assign x1a.cmd_wdata  = '0;
    assign x1a.cmd_mask   = 2'b11;
    assign x1b.cmd_valid  = 1'b0;
    assign x1b.cmd_write  = 1'b0;
    assign x1b.cmd_addr   = '0;
    assign x1b.cmd_wdata  = '0;
    assign x1b.cmd_mask   = 2'b00;
    assign x15a.cmd_valid = lv[1];
    assign x15a.cmd_write = 1'b0;
    assign x15a.cmd_addr  = '0;
    assign x15a.cmd_wdata = '0;
    assign x15a.cmd_mask  = 2'b11;
    assign x15b.cmd_valid = 1'b0;
    assign x15b.cmd_write = 1'b0;
    assign x15b.cmd_addr  = '0;
    assign x15b.cmd_wdata = '0;
    assign x15b.cmd_mask  = 2'b00;
    assign lr  = {x15a.cmd_ready, x1a.cmd_ready};
    assign lrv = {x15a.rsp_valid, x1a.rsp_valid};

    sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
        .io_mainClk(clk), .io_asyncResetn(rst_n), .io_a(x1a), .io_b(x1b),
        .io_sram_addr(l_addr[0]), .io_sram_dat_read(16'h5A5A), .io_sram_dat_write(l_dw[0]),
        .io_sram_dat_writeEnable(l_wen[0]), .io_sram_cs(l_cs[0]), .io_sram_we(l_we[0]),
        .io_sram_oe(l_oe[0]), .io_sram_ub(l_ub[0]), .io_sram_lb(l_lb[0])
    );
    sram_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
        .io_mainClk(clk), .io_asyncResetn(rst_n), .io_a(x15a), .io_b(x15b),
        .io_sram_addr(l_addr[1]), .io_sram_dat_read(16'h5A5A), .io_sram_dat_write(l_dw[1]),
        .io_sram_dat_writeEnable(l_wen[1]), .io_sram_cs(l_cs[1]), .io_sram_we(l_we[1]),
        .io_sram_oe(l_oe[1]), .io_sram_ub(l_ub[1]), .io_sram_lb(l_lb[1])
    );

    // Reference model state: at most one transaction in flight, timed from its handshake.
    bit            mon_en = 1'b0;
    int            cyc = 0;
    bit            inflight = 1'b0;
    int            t0 = 0;
    bit            p_port, p_w, p_known;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wd, p_exp;
    logic [1:0]    p_m;
    bit            last = 1'b1;
    int            glog[$];
    logic [15:0]   ref_mem[int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                inflight = 1'b0;
                last     = 1'b1;
            end else begin
                int k;
                bit ph, acc, ga, gb;
                cyc++;
                k = cyc - t0;
                if (inflight && k >= W + 3) inflight = 1'b0;
                ph  = inflight && k >= 1 && k <= W + 2;
                acc = ph && k >= 2 && k <= W + 1;
                ga  = cv[0] && (!cv[1] || !RR || last);
                gb  = cv[1] && !ga;
                chk("ready_a", {31'd0, rdy[0]}, {31'd0, !inflight && ga});
                chk("ready_b", {31'd0, rdy[1]}, {31'd0, !inflight && gb});
                chk("cs", {31'd0, s_cs}, {31'd0, !ph});
                chk("we", {31'd0, s_we}, {31'd0, !(acc && p_w)});
                chk("oe", {31'd0, s_oe}, {31'd0, !(acc && !p_w)});
                chk("dat_oe", {31'd0, s_wen}, {31'd0, ph && p_w});
                chk("lb", {31'd0, s_lb}, {31'd0, ph ? (p_w ? !p_m[0] : 1'b0) : 1'b1});
                chk("ub", {31'd0, s_ub}, {31'd0, ph ? (p_w ? !p_m[1] : 1'b0) : 1'b1});
                if (ph) chk("addr", 32'(s_addr), 32'(p_addr));
                if (ph && p_w) chk("dat_write", 32'(s_dw), 32'(p_wd));
                chk("rsp_a", {31'd0, rv[0]}, {31'd0, inflight && k == W + 2 && !p_port});
                chk("rsp_b", {31'd0, rv[1]}, {31'd0, inflight && k == W + 2 && p_port});
                if (inflight && k == W + 2 && !p_w && p_known)
                    chk(p_port ? "rdata_b" : "rdata_a",
                        32'(p_port ? ifb.rsp_rdata : ifa.rsp_rdata), 32'(p_exp));
                if ((rdy[0] && cv[0]) || (rdy[1] && cv[1])) begin
                    p_port   = rdy[1] && cv[1];
                    p_w      = cw[p_port];
                    p_addr   = ca[p_port];
                    p_wd     = cd[p_port];
                    p_m      = cm[p_port];
                    inflight = 1'b1;
                    t0       = cyc;
                    last     = p_port;
                    glog.push_back(int'(p_port));
                    if (!p_w) begin
                        p_known = ref_mem.exists(int'(p_addr));
                        p_exp   = p_known ? ref_mem[int'(p_addr)] : 16'h0;
                    end else if (p_m == 2'b11) begin
                        ref_mem[int'(p_addr)] = p_wd;
                    end else if (ref_mem.exists(int'(p_addr))) begin
                        if (p_m[0]) ref_mem[int'(p_addr)][7:0]  = p_wd[7:0];
                        if (p_m[1]) ref_mem[int'(p_addr)][15:8] = p_wd[15:8];
                    end
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic send(input int p, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [1:0] m, input bit keep);
        int n = 0;
        cv[p] = 1'b1; cw[p] = w; ca[p] = a; cd[p] = d; cm[p] = m;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[p] && n < 300);
        chk($sformatf("accept_%0d", p), {31'd0, rdy[p]}, 32'd1);
        step();
        if (!keep) cv[p] = 1'b0;
    endtask

    task automatic lat(input int k, input int w);
        int n = 0;
        lv[k] = 1'b1;
        @(negedge clk);
        chk("lat_ready", {31'd0, lr[k]}, 32'd1);
        do begin
            @(negedge clk);
            n++;
            chk("lat_busy_ready", {31'd0, lr[k]}, 32'd0);
        end while (!lrv[k] && n < 40);
        chk($sformatf("latency_w%0d", w), 32'(n), 32'(w + 2));
        step();
        lv[k] = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        int first;
        for (int i = 0; i < 2; i++) begin
            cv[i] = 1'b0; cw[i] = 1'b0; ca[i] = '0; cd[i] = '0; cm[i] = 2'b00; lv[i] = 1'b0;
        end
        fork monitor(); join_none

        repeat (3) step();
        chk("rst_cs", {31'd0, s_cs}, 32'd1);
        chk("rst_we", {31'd0, s_we}, 32'd1);
        chk("rst_oe", {31'd0, s_oe}, 32'd1);
        chk("rst_ub", {31'd0, s_ub}, 32'd1);
        chk("rst_lb", {31'd0, s_lb}, 32'd1);
        chk("rst_dat_oe", {31'd0, s_wen}, 32'd0);
        chk("rst_addr", 32'(s_addr), 32'd0);
        chk("rst_dat_write", 32'(s_dw), 32'd0);
        chk("rst_rsp", 32'(rv), 32'd0);
        chk("rst_rdata_a", 32'(ifa.rsp_rdata), 32'd0);
        chk("rst_rdata_b", 32'(ifb.rsp_rdata), 32'd0);
        chk("rst_ready", 32'(rdy), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();

        send(0, 1'b1, 18'h00123, 16'hBEEF, 2'b11, 1'b0);
        repeat (W + 3) step();
        chk("mem_full_write", 32'(sram[9'h123]), 32'h0000BEEF);
        send(0, 1'b0, 18'h00123, 16'h0000, 2'b11, 1'b0);
        repeat (W + 3) step();
        chk("read_back", 32'(ifa.rsp_rdata), 32'h0000BEEF);
        send(0, 1'b1, 18'h00123, 16'h12AB, 2'b01, 1'b0);
        repeat (W + 3) step();
        chk("mem_low_byte", 32'(sram[9'h123]), 32'h0000BEAB);
        send(1, 1'b1, 18'h00123, 16'h5555, 2'b00, 1'b0);
        repeat (W + 3) step();
        chk("mem_mask00", 32'(sram[9'h123]), 32'h0000BEAB);
        send(1, 1'b0, 18'h00123, 16'h0000, 2'b11, 1'b0);
        repeat (W + 3) step();
        chk("read_back_b", 32'(ifb.rsp_rdata), 32'h0000BEAB);

        for (int i = 0; i < 16; i++) send(i % 2, 1'b1, 18'(i), 16'($urandom), 2'b11, 1'b0);

        glog.delete();
        first = RR ? (last ? 0 : 1) : 0;
        fork
            for (int i = 0; i < 6; i++) send(0, 1'b1, 18'(i), 16'($urandom), 2'b11, i < 5);
            for (int i = 0; i < 6; i++) send(1, 1'b0, 18'(i + 8), 16'h0, 2'b11, i < 5);
        join
        chk("tie_count", 32'(glog.size()), 32'd12);
        for (int i = 0; i < 12 && i < glog.size(); i++)
            chk($sformatf("tie_grant%0d", i), 32'(glog[i]),
                32'(RR ? (first ^ (i % 2)) : (i >= 6 ? 1 : 0)));

        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) step();
                send(0, 1'($urandom_range(0, 1)), 18'($urandom_range(0, 15)),
                     16'($urandom), 2'($urandom), 1'b0);
            end
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) step();
                send(1, 1'($urandom_range(0, 1)), 18'($urandom_range(0, 15)),
                     16'($urandom), 2'($urandom), 1'b0);
            end
        join
        repeat (W + 4) step();

        mon_en = 1'b0;
        cv[0] = 1'b1; cw[0] = 1'b1; ca[0] = 18'h00040; cd[0] = 16'hA5A5; cm[0] = 2'b11;
        @(negedge clk);
        chk("rst_test_ready", {31'd0, rdy[0]}, 32'd1);
        step();
        cv[0] = 1'b0;
        step();
        chk("rst_test_we_low", {31'd0, s_we}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_we", {31'd0, s_we}, 32'd1);
        chk("async_cs", {31'd0, s_cs}, 32'd1);
        chk("async_dat_oe", {31'd0, s_wen}, 32'd0);
        chk("async_lb", {31'd0, s_lb}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("async_no_rsp", 32'(rv), 32'd0);
        end
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        glog.delete();
        fork
            send(0, 1'b0, 18'h00005, 16'h0, 2'b11, 1'b0);
            send(1, 1'b0, 18'h00006, 16'h0, 2'b11, 1'b0);
        join
        chk("post_reset_first_grant", 32'(glog.size() > 0 ? glog[0] : 9), 32'd0);
        repeat (W + 4) step();

        lat(0, 1);
        lat(1, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
